ibex_rf_write_arbiter: RTL and testbench
========================================

IBEX_RF_WRITE_ARBITER -- requirements
Module: ibex_rf_write_arbiter

Interface
REQ-001 SHALL have parameter RV32E, default 0, meaning 16 architectural registers when 1, otherwise 32.
REQ-002 SHALL have parameter DataWidth, default 32, meaning width of write data.
REQ-003 SHALL have parameter WordZeroVal, default all-zero, meaning the value written by the clear sequence.
REQ-004 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req0_valid_i / req1_valid_i  input  1  each requester presents a write.
REQ-007 SHALL have ports req0_ready_o / req1_ready_o  output  1  the write is accepted this cycle.
REQ-008 SHALL have ports req0_addr_i / req1_addr_i  input  5  destination register index.
REQ-009 SHALL have ports req0_data_i / req1_data_i  input  DataWidth  write data.
REQ-010 SHALL have port clear_req_i  input  1  start the clear sequence (level-sampled).
REQ-011 SHALL have port busy_o  output  1  the clear sequence is in progress.
REQ-012 SHALL have port clear_done_o  output  1  single-cycle pulse when the clear sequence completes.
REQ-013 SHALL have ports rf_waddr_o  output  5,  rf_wdata_o  output  DataWidth,  rf_we_o  output  1  the register-file write port, all registered.
REQ-014 SHALL have port err_o  output  1  registered single-cycle pulse on an accepted illegal address.

Function
REQ-015 SHALL implement the FSM states IDLE, CLEAR and DONE; transitions: IDLE->CLEAR on clear_req_i, CLEAR->DONE after the last index is issued, DONE->IDLE unconditionally.
REQ-016 SHALL, in IDLE, accept at most one request per cycle: ready is asserted combinationally only for the granted requester, and only when its valid is high.
REQ-017 SHALL grant the sole valid requester when only one is valid.
REQ-018 SHALL, when both requesters are valid, grant the requester not served by the most recent accept (round-robin), updating the pointer only on an accept.
REQ-019 SHALL, for an accepted request, drive rf_we_o=1, rf_waddr_o=addr and rf_wdata_o=data in the following cycle (latency 1); otherwise rf_we_o=0 in that cycle.
REQ-020 SHALL accept (ready=1) a write to index 0 but keep rf_we_o=0 and err_o=0 for it.
REQ-021 SHALL, when RV32E=1, accept a write with addr[4]=1, keep rf_we_o=0, and pulse err_o=1 in the following cycle.
REQ-022 SHALL, when clear_req_i=1 in IDLE, give priority to the clear: no request is accepted that cycle, and the FSM enters CLEAR next cycle.
REQ-023 SHALL, in CLEAR, hold both ready outputs at 0, keep busy_o=1, and issue one write per cycle of WordZeroVal to indices 1..NUM_WORDS-1 in ascending order via the registered port.
REQ-024 SHALL set NUM_WORDS = 16 when RV32E=1, otherwise 32; index 0 is never written by the clear sequence.
REQ-025 SHALL ignore clear_req_i while in CLEAR or DONE.
REQ-026 SHALL, in DONE, pulse clear_done_o=1 for exactly one cycle and keep both ready outputs at 0.
REQ-027 SHALL, after DONE, accept requests in IDLE again (busy_o=0).
REQ-028 SHALL produce no combinational path from any input to rf_we_o, rf_waddr_o, rf_wdata_o, err_o, busy_o or clear_done_o.

Reset
REQ-029 SHALL, while rst_i=1, force: state IDLE, round-robin pointer favouring req0, clear counter 1, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, err_o=0, busy_o=0, clear_done_o=0, both ready outputs 0.
REQ-030 SHALL, when reset is asserted mid-CLEAR, abort the sequence with no clear_done_o pulse and restart from IDLE.

Verification
REQ-031 SHALL cover: req0 only, addr=5, data=0xA5A5A5A5 -> ready0=1; next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xA5A5A5A5.
REQ-032 SHALL cover: both valid for 4 cycles, starting after reset -> grants req0, req1, req0, req1; each write appears one cycle later.
REQ-033 SHALL cover: req1 addr=0 -> ready1=1; next cycle rf_we_o=0, err_o=0. With RV32E=1 and addr=17 -> rf_we_o=0, err_o=1 for one cycle.
REQ-034 SHALL cover: clear_req_i and req0_valid_i in the same cycle (RV32E=0) -> ready0=0; busy_o=1 for 31 cycles with rf_waddr_o=1..31 and rf_wdata_o=0; then clear_done_o=1 for one cycle; req0 is accepted afterwards.
REQ-035 SHALL cover: rst_i pulsed at the 10th CLEAR cycle -> all outputs 0 immediately; no clear_done_o pulse; a new clear restarts at index 1.

Source files
------------

// File: rtl/ibex_rf_write_arbiter.sv
// rtl/ibex_rf_write_arbiter.sv - two-requester register-file write arbiter with clear sequence
module ibex_rf_write_arbiter #(
    parameter bit                   RV32E       = 1'b0,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  logic [4:0]           req0_addr_i,
    input  logic [DataWidth-1:0] req0_data_i,
    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  logic [4:0]           req1_addr_i,
    input  logic [DataWidth-1:0] req1_data_i,
    input  logic                 clear_req_i,
    output logic                 busy_o,
    output logic                 clear_done_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic                 err_o
);

    localparam int unsigned NumWords = RV32E ? 16 : 32;
    localparam logic [4:0]  LastIdx  = 5'(NumWords - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_e;

    state_e               state_q;
    logic                 rr_q;       // 1: req1 wins the next tie
    logic [4:0]           cnt_q;
    logic [4:0]           waddr_q;
    logic [DataWidth-1:0] wdata_q;
    logic                 we_q;
    logic                 err_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 accept_en;
    logic                 gnt0;
    logic                 gnt1;
    logic [4:0]           sel_addr;
    logic [DataWidth-1:0] sel_data;
    logic                 sel_illegal;

    assign accept_en    = (state_q == IDLE) && !clear_req_i && !rst_i;
    assign gnt0         = req0_valid_i && (!req1_valid_i || !rr_q);
    assign gnt1         = req1_valid_i && (!req0_valid_i || rr_q);
    assign req0_ready_o = accept_en && gnt0;
    assign req1_ready_o = accept_en && gnt1;

    assign sel_addr    = gnt1 ? req1_addr_i : req0_addr_i;
    assign sel_data    = gnt1 ? req1_data_i : req0_data_i;
    assign sel_illegal = RV32E && sel_addr[4];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= 5'd1;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear_req_i) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        cnt_q   <= 5'd1;
                    end else if (req0_ready_o || req1_ready_o) begin
                        rr_q    <= req0_ready_o;
                        waddr_q <= sel_addr;
                        wdata_q <= sel_data;
                        // x0 is hardwired; accepted but never written
                        we_q    <= !sel_illegal && (sel_addr != 5'd0);
                        err_q   <= sel_illegal;
                    end
                end
                CLEAR: begin
                    we_q    <= 1'b1;
                    waddr_q <= cnt_q;
                    wdata_q <= WordZeroVal;
                    if (cnt_q == LastIdx) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= 5'd1;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rf_waddr_o   = waddr_q;
    assign rf_wdata_o   = wdata_q;
    assign rf_we_o      = we_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;
    assign clear_done_o = done_q;

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// tb/tb_ibex_rf_write_arbiter.sv - scoreboard bench for RV32I and RV32E arbiter instances
module tb_ibex_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0, clr = 1'b0;
    logic [4:0]  a0 = '0, a1 = '0;
    logic [31:0] d0 = '0, d1 = '0;

    logic [1:0]  rdy0, rdy1, busy, done, we, err;
    logic [4:0]  waddr [2];
    logic [31:0] wdata [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        bit          is_err;
        logic [4:0]  addr;
        logic [31:0] data;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    int  cs [2]       = '{-1000, -1000};
    int  last_srv [2] = '{1, 1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ibex_rf_write_arbiter #(
            .RV32E      (g == 1),
            .DataWidth  (32),
            .WordZeroVal((g == 1) ? 32'h0000_00EE : 32'h0)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .req0_valid_i(v0),
            .req0_ready_o(rdy0[g]),
            .req0_addr_i (a0),
            .req0_data_i (d0),
            .req1_valid_i(v1),
            .req1_ready_o(rdy1[g]),
            .req1_addr_i (a1),
            .req1_data_i (d1),
            .clear_req_i (clr),
            .busy_o      (busy[g]),
            .clear_done_o(done[g]),
            .rf_waddr_o  (waddr[g]),
            .rf_wdata_o  (wdata[g]),
            .rf_we_o     (we[g]),
            .err_o       (err[g])
        );
    end

    function automatic int nw(int k);
        return (k == 1) ? 16 : 32;
    endfunction

    function automatic logic [31:0] zval(int k);
        return (k == 1) ? 32'h0000_00EE : 32'h0;
    endfunction

    task automatic chk(int k, string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL dut%0d %s cyc=%0d got=%h want=%h", k, nm, cyc, act, exp);
        end
    endtask

    task automatic push(int k, int c, bit is_err, logic [4:0] addr, logic [31:0] data);
        ev_t e;
        e.cyc = c; e.is_err = is_err; e.addr = addr; e.data = data;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Reference model: computes grants and schedules expected port events.
    int          m_win;
    bit          m_blk;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_e0, m_e1;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_e0 = 1'b0; m_e1 = 1'b0;
            if (rst) begin
                if (k == 0) q0.delete(); else q1.delete();
                cs[k]       = -1000;
                last_srv[k] = 1;
            end else begin
                m_blk = (cyc >= cs[k] + 1) && (cyc <= cs[k] + nw(k));
                if (!m_blk && clr) begin
                    cs[k] = cyc;
                    for (int i = 1; i < nw(k); i++)
                        push(k, cyc + 1 + i, 1'b0, 5'(i), zval(k));
                end else if (!m_blk && (v0 || v1)) begin
                    if (v0 && v1) m_win = (last_srv[k] == 0) ? 1 : 0;
                    else          m_win = v1 ? 1 : 0;
                    last_srv[k] = m_win;
                    m_e0   = (m_win == 0);
                    m_e1   = (m_win == 1);
                    m_addr = m_win ? a1 : a0;
                    m_data = m_win ? d1 : d0;
                    if (k == 1 && m_addr >= 16) push(k, cyc + 1, 1'b1, m_addr, m_data);
                    else if (m_addr != 0)       push(k, cyc + 1, 1'b0, m_addr, m_data);
                end
            end
            chk(k, "ready0", 32'(rdy0[k]), 32'(m_e0));
            chk(k, "ready1", 32'(rdy1[k]), 32'(m_e1));
        end
    end

    // Monitor: pops scheduled events and checks the registered outputs.
    ev_t mon_e;
    bit  mon_has;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                chk(k, "rst_we", 32'(we[k]), 0);
                chk(k, "rst_err", 32'(err[k]), 0);
                chk(k, "rst_busy", 32'(busy[k]), 0);
                chk(k, "rst_done", 32'(done[k]), 0);
                chk(k, "rst_waddr", 32'(waddr[k]), 0);
                chk(k, "rst_wdata", wdata[k], 0);
            end else begin
                mon_has = 1'b0;
                if (k == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin
                    mon_e = q0.pop_front(); mon_has = 1'b1;
                end else if (k == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin
                    mon_e = q1.pop_front(); mon_has = 1'b1;
                end
                chk(k, "we", 32'(we[k]), 32'(mon_has && !mon_e.is_err));
                chk(k, "err", 32'(err[k]), 32'(mon_has && mon_e.is_err));
                if (mon_has && !mon_e.is_err) begin
                    chk(k, "waddr", 32'(waddr[k]), 32'(mon_e.addr));
                    chk(k, "wdata", wdata[k], mon_e.data);
                end
                chk(k, "busy", 32'(busy[k]),
                    32'((cyc >= cs[k] + 1) && (cyc <= cs[k] + nw(k) - 1)));
                chk(k, "clear_done", 32'(done[k]), 32'(cyc == cs[k] + nw(k)));
            end
        end
    end

    task automatic drive(bit nv0, bit nv1, bit nclr, logic [4:0] na0, logic [4:0] na1,
                         logic [31:0] nd0, logic [31:0] nd1);
        @(posedge clk);
        #1;
        v0 = nv0; v1 = nv1; clr = nclr;
        a0 = na0; a1 = na1; d0 = nd0; d1 = nd1;
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        idle(3);
        @(posedge clk); #1; rst = 1'b0;
        // ties right after reset alternate starting with req0
        for (int i = 0; i < 4; i++)
            drive(1, 1, 0, 5'(i + 1), 5'(i + 9), 32'h1000 + i, 32'h2000 + i);
        idle(1);
        drive(1, 0, 0, 5'd5, 5'd0, 32'hA5A5A5A5, 32'h0);
        idle(1);
        drive(0, 1, 0, 5'd0, 5'd0, 32'h0, 32'hDEAD0000);
        drive(0, 1, 0, 5'd0, 5'd17, 32'h0, 32'h00001717);
        idle(2);
        drive(1, 0, 1, 5'd7, 5'd0, 32'h77, 32'h0);
        idle(40);
        drive(1, 0, 0, 5'd3, 5'd0, 32'h33, 32'h0);
        idle(2);
        // reset lands in the 10th clear cycle
        drive(0, 0, 1, 5'd0, 5'd0, 32'h0, 32'h0);
        idle(9);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1; rst = 1'b0;
        idle(2);
        drive(0, 0, 1, 5'd0, 5'd0, 32'h0, 32'h0);
        idle(40);
        for (int i = 0; i < 400; i++)
            drive(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 50) == 0,
                  5'($urandom), 5'($urandom), $urandom, $urandom);
        idle(40);
        chk(0, "drain", q0.size(), 0);
        chk(1, "drain", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
